// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: state encoding, default stage
// count and the fixed stage ordering of the datapath.
package layer_sched_pkg;

    localparam int LS_NUM_STAGE = 4;

    localparam int ST_UNSHUF = 0;
    localparam int ST_CONV1  = 1;
    localparam int ST_CONV2  = 2;
    localparam int ST_CONV3  = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s == S_IDLE || s == S_ERR);
    endfunction

endpackage

// File: rtl/layer_sched_timer.sv
// Per-stage RUN cycle counter; saturates instead of wrapping and flags the
// cycle in which the running count reaches a nonzero limit.
module stage_timer #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] count_reg;
    logic [TO_W:0]   count_inc;

    assign count_inc = {1'b0, count_reg} + {{TO_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && count_reg != '1) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expiry is judged against the count this cycle will contribute, so a
    // limit of N allows exactly N RUN cycles.
    assign expired = inc && (limit != '0) && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/layer_sched.sv
// Sequences the enabled datapath stages one at a time, hands the shared SRAM
// to the running stage, and guards each stage with an optional timeout.
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int NUM_STAGE = LS_NUM_STAGE,
    parameter int TO_W      = 16,
    parameter int GAP_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_STAGE-1:0] cfg_mask,
    input  logic [TO_W-1:0]      cfg_timeout,
    input  logic [NUM_STAGE-1:0] stage_valid,
    output logic [NUM_STAGE-1:0] stage_enable,
    output logic [1:0]           sram_owner,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CUR_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CUR_W-1:0] LAST_CUR = CUR_W'(NUM_STAGE - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

    state_t               state_reg, state_next;
    logic [CUR_W-1:0]     cur_reg, cur_next;
    logic [NUM_STAGE-1:0] mask_reg, mask_next;
    logic [TO_W-1:0]      timeout_reg, timeout_next;
    logic [GAP_W-1:0]     gap_reg, gap_next;
    logic [NUM_STAGE-1:0] stage_enable_reg, stage_enable_next;
    logic [1:0]           sram_owner_reg, sram_owner_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;

    logic timer_clear;
    logic timer_inc;
    logic timer_expired;

    stage_timer #(
        .TO_W (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .limit   (timeout_reg),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            cur_reg          <= '0;
            mask_reg         <= '0;
            timeout_reg      <= '0;
            gap_reg          <= '0;
            stage_enable_reg <= '0;
            sram_owner_reg   <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cur_reg          <= cur_next;
            mask_reg         <= mask_next;
            timeout_reg      <= timeout_next;
            gap_reg          <= gap_next;
            stage_enable_reg <= stage_enable_next;
            sram_owner_reg   <= sram_owner_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_next     = cur_reg;
        mask_next    = mask_reg;
        timeout_next = timeout_reg;
        gap_next     = gap_reg;
        err_next     = err_reg;
        done_next    = 1'b0;

        case (state_reg)
            S_IDLE, S_ERR: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next   = S_SEL;
                    cur_next     = '0;
                    mask_next    = cfg_mask;
                    timeout_next = cfg_timeout;
                    err_next     = 1'b0;
                end
            end
            S_SEL: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (mask_reg[cur_reg]) begin
                    state_next = S_RUN;
                end else if (cur_reg == LAST_CUR) begin
                    state_next = S_FIN;
                end else begin
                    cur_next = cur_reg + 1'b1;
                end
            end
            S_RUN: begin
                // A completion seen in the same cycle as expiry still counts.
                if (abort) begin
                    state_next = S_IDLE;
                end else if (stage_valid[cur_reg]) begin
                    gap_next = '0;
                    if (GAP_CYC > 0) begin
                        state_next = S_GAP;
                    end else if (cur_reg == LAST_CUR) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_SEL;
                        cur_next   = cur_reg + 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next = S_ERR;
                    err_next   = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (gap_reg == LAST_GAP) begin
                    if (cur_reg == LAST_CUR) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_SEL;
                        cur_next   = cur_reg + 1'b1;
                    end
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
                done_next  = !abort;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The SRAM follows the stage only at the moment it is granted RUN, so
    // ownership never moves under a live enable.
    always_comb begin
        sram_owner_next = sram_owner_reg;
        if (state_reg == S_SEL && state_next == S_RUN) begin
            sram_owner_next = 2'(cur_reg);
        end
    end

    assign busy_next   = is_busy(state_next);
    assign timer_clear = (state_next == S_RUN) && (state_reg != S_RUN);
    assign timer_inc   = (state_reg == S_RUN);

    generate
        for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_enable
            assign stage_enable_next[gi] = (state_next == S_RUN) &&
                                           (cur_next == CUR_W'(gi));
        end
    endgenerate

    assign stage_enable = stage_enable_reg;
    assign sram_owner   = sram_owner_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_layer_sched.sv
// Randomized bench for layer_sched: a trace model derived from the stage
// sequencing rules predicts every output cycle by cycle.
module tb_layer_sched;
    import layer_sched_pkg::*;

    localparam int NS  = 4;
    localparam int TW  = 16;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [NS-1:0] cfg_mask;
    logic [TW-1:0] cfg_timeout;
    logic [NS-1:0] stage_valid;
    logic [NS-1:0] stage_enable;
    logic [1:0]    sram_owner;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    layer_sched #(
        .NUM_STAGE (NS),
        .TO_W      (TW),
        .GAP_CYC   (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_mask     (cfg_mask),
        .cfg_timeout  (cfg_timeout),
        .stage_valid  (stage_valid),
        .stage_enable (stage_enable),
        .sram_owner   (sram_owner),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        logic [NS-1:0] en;
        logic [1:0]    own;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat_cfg[NS];
    int   hi_cnt[NS];
    logic [1:0] model_owner = 2'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [NS-1:0] en, input logic [1:0] own,
                            input logic b, input logic d, input logic e);
        exp_t x;
        x.en = en; x.own = own; x.busy = b; x.done = d; x.err = e;
        exp_q.push_back(x);
    endtask

    // Expected output trace starting the cycle after start is accepted.
    task automatic build_trace(input logic [NS-1:0] m, input int to);
        int  len;
        bit  timed_out;
        timed_out = 0;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            push_exp('0, model_owner, 1, 0, 0);
            if (m[i]) begin
                model_owner = 2'(i);
                len = lat_cfg[i] + 1;
                if (to != 0 && len > to) begin
                    len = to;
                    timed_out = 1;
                end
                for (int c = 0; c < len; c++) push_exp(NS'(1 << i), model_owner, 1, 0, 0);
                if (timed_out) break;
                for (int c = 0; c < GAP; c++) push_exp('0, model_owner, 1, 0, 0);
            end
        end
        if (timed_out) begin
            for (int c = 0; c < 4; c++) push_exp('0, model_owner, 0, 0, 1);
        end else begin
            push_exp('0, model_owner, 1, 0, 0);
            push_exp('0, model_owner, 0, 1, 0);
            for (int c = 0; c < 3; c++) push_exp('0, model_owner, 0, 0, 0);
        end
    endtask

    task automatic drive_valid();
        for (int i = 0; i < NS; i++) begin
            if (stage_enable[i]) begin
                hi_cnt[i]++;
                stage_valid[i] = (hi_cnt[i] >= lat_cfg[i] + 1);
            end else begin
                hi_cnt[i] = 0;
                stage_valid[i] = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    // abort_en == 0: abort at trace index abort_at; otherwise abort on the
    // abort_at-th cycle (0-based) whose expected enable equals abort_en.
    task automatic run(input logic [NS-1:0] m, input int to,
                       input int abort_at, input logic [NS-1:0] abort_en);
        int   k;
        int   en_seen;
        exp_t last;
        start = 1; cfg_mask = m; cfg_timeout = TW'(to); abort = 0;
        build_trace(m, to);
        $display("run mask=%b timeout=%0d lat=%0d/%0d/%0d/%0d abort_at=%0d abort_en=%b",
                 m, to, lat_cfg[0], lat_cfg[1], lat_cfg[2], lat_cfg[3], abort_at, abort_en);
        @(posedge clk); #1;
        start = 0;
        k = 0;
        en_seen = 0;
        while (k < exp_q.size()) begin
            check_val($sformatf("enable[%0d]", k), 32'(stage_enable), 32'(exp_q[k].en));
            check_val($sformatf("owner[%0d]", k),  32'(sram_owner),   32'(exp_q[k].own));
            check_val($sformatf("busy[%0d]", k),   32'(busy),         32'(exp_q[k].busy));
            check_val($sformatf("done[%0d]", k),   32'(done),         32'(exp_q[k].done));
            check_val($sformatf("err[%0d]", k),    32'(err),          32'(exp_q[k].err));
            drive_valid();
            abort = 0;
            start = 0;
            if (exp_q[k].busy) begin
                if ((abort_en == '0 && k == abort_at) ||
                    (abort_en != '0 && exp_q[k].en == abort_en && en_seen == abort_at)) begin
                    abort = 1;
                    last = exp_q[k];
                    while (exp_q.size() > k + 1) void'(exp_q.pop_back());
                    for (int c = 0; c < 3; c++) push_exp('0, last.own, 0, 0, last.err);
                    model_owner = last.own;
                end
                if ($urandom_range(0, 3) == 0) begin
                    start = 1;
                    cfg_mask = NS'($urandom);
                    cfg_timeout = TW'($urandom_range(0, 3));
                end
            end
            if (abort_en != '0 && exp_q[k].en == abort_en) en_seen++;
            @(posedge clk); #1;
            k++;
        end
        start = 0;
        abort = 0;
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < NS; i++) lat_cfg[i] = l;
    endtask

    initial begin
        int guard;
        rst_n = 0; start = 0; abort = 0; cfg_mask = '0; cfg_timeout = '0; stage_valid = '0;
        for (int i = 0; i < NS; i++) hi_cnt[i] = 0;
        set_lat(10);
        #12;
        check_val("reset_enable", 32'(stage_enable), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        run(4'b1111, 0, -1, '0);
        run(4'b0101, 0, -1, '0);
        set_lat(10);
        run(4'b1111, 5, -1, '0);
        check_val("timeout_err_sticky", 32'(err), 32'd1);
        run(4'b0001, 0, -1, '0);
        run(4'b1111, 0, 2, NS'(1 << ST_CONV2));
        run(4'b0000, 0, -1, '0);
        set_lat(3);
        run(4'b0010, 4, -1, '0);
        run(4'b0010, 3, -1, '0);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NS; i++) lat_cfg[i] = $urandom_range(0, 12);
            run(NS'($urandom),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 14)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1, '0);
        end

        // Asynchronous reset while a stage is running.
        set_lat(20);
        start = 1; cfg_mask = NS'(1 << ST_CONV1); cfg_timeout = '0;
        @(posedge clk); #1;
        start = 0;
        guard = 0;
        while (stage_enable == '0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("reach_run", 32'(guard < 20), 32'd1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check_val("rst_enable", 32'(stage_enable), 32'd0);
        check_val("rst_owner", 32'(sram_owner), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        model_owner = 2'd0;
        for (int i = 0; i < NS; i++) hi_cnt[i] = 0;
        @(posedge clk); #1;
        set_lat(2);
        run(4'b1000, 0, -1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter NUM_STAGE, default 4, meaning number of sequenced datapath stages (unshuffle, conv1, conv2, conv3).
REQ-002 SHALL have parameter TO_W, default 16, meaning width of the per-stage timeout counter.
REQ-003 SHALL have parameter GAP_CYC, default 2, meaning enable-low cycles inserted between stages.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to run the enabled stage chain.
REQ-007 SHALL have port abort  input  1  synchronous request to stop and return to IDLE.
REQ-008 SHALL have port cfg_mask  input  NUM_STAGE  1 = run stage i, 0 = skip; sampled on accepted start.
REQ-009 SHALL have port cfg_timeout  input  TO_W  max RUN cycles per stage; sampled on accepted start; 0 = no timeout.
REQ-010 SHALL have port stage_valid  input  NUM_STAGE  level done flag from stage i, held until its enable drops.
REQ-011 SHALL have port stage_enable  output  NUM_STAGE  registered, at most one bit high (onehot0).
REQ-012 SHALL have port sram_owner  output  2  registered index of the stage owning the shared SRAM ports.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE and ERR.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the chain completes.
REQ-015 SHALL have port err  output  1  sticky timeout flag, cleared only by an accepted start or reset.

Function
REQ-016 SHALL implement states IDLE, SEL, RUN, GAP, FIN, ERR.
REQ-017 IDLE: start accepted -> latch cfg_mask/cfg_timeout, clear err, cur=0, go SEL; start while busy SHALL be ignored.
REQ-018 SEL: if latched mask[cur]=1 go RUN; else if cur=NUM_STAGE-1 go FIN; else cur+1, stay SEL (one cycle per skipped stage).
REQ-019 RUN: stage_enable[cur]=1 from the cycle after SEL; sram_owner=cur; timeout counter increments each RUN cycle.
REQ-020 RUN: stage_valid[cur]=1 -> enable drops next cycle, go GAP; stage_valid of any other stage SHALL be ignored.
REQ-021 RUN: counter reaches cfg_timeout (nonzero) with stage_valid[cur]=0 -> go ERR, err=1, enables low; valid in the same cycle wins over timeout.
REQ-022 GAP: all enables low for exactly GAP_CYC cycles; sram_owner holds cur; then cur=NUM_STAGE-1 -> FIN, else cur+1 -> SEL.
REQ-023 FIN: done=1 for one cycle, then IDLE.
REQ-024 ERR: all enables low, busy=0; start accepted as in IDLE; abort -> IDLE with err held.
REQ-025 abort in any busy state SHALL force IDLE next cycle with all enables low, no done pulse; abort wins over start and valid.
REQ-026 cfg_mask=0 at start SHALL walk SEL NUM_STAGE cycles then FIN; no enable ever rises.
REQ-027 Timeout counter SHALL saturate, clear on entry to RUN, and never wrap.
REQ-028 sram_owner SHALL change only on SEL->RUN transitions, never while an enable is high.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, cur=0, stage_enable=0, sram_owner=0, busy=0, done=0, err=0, counters=0, latched config=0.
REQ-030 Reset mid-RUN SHALL drop the active enable immediately (asynchronously) without a done pulse.

Structure
REQ-031 State encoding, NUM_STAGE, stage index constants (ST_UNSHUF=0, ST_CONV1=1, ST_CONV2=2, ST_CONV3=3) SHALL live in a shared package.
REQ-032 The timeout counter SHALL be a sub-module named stage_timer (clear, inc, limit, expired).

Verification
REQ-033 start, mask=4'b1111, timeout=0, each stage asserts valid 10 cycles after its enable -> enables 0001,0010,0100,1000 in order, 2 low cycles between, done one pulse, err=0.
REQ-034 mask=4'b0101 -> only enable[0] and enable[2] rise; sram_owner 0 then 2; done after stage 2's GAP.
REQ-035 timeout=5, stage 1 never valid -> enable[1] high exactly 5 cycles, err=1, busy=0; following start clears err.
REQ-036 abort in RUN of stage 2 -> enable[2] low next cycle, state IDLE, done never pulses; start during busy ignored.
REQ-037 mask=0 -> done pulses 1+NUM_STAGE+1 cycles after start, no enable; rst_n low mid-RUN -> all outputs 0 at once.
